// File: rtl/sram_port_arbiter_pkg.sv
// Shared helpers for the SRAM port arbiter: a fixed-width priority
// encoder used by the round-robin select. Requester vectors narrower than
// MAX_REQ are zero-extended before encoding.
package sram_port_arbiter_pkg;

  localparam int MAX_REQ   = 8;
  localparam int MAX_IDX_W = 3;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [MAX_IDX_W-1:0] lsb_index(input logic [MAX_REQ-1:0] v);
    logic [MAX_IDX_W-1:0] r;
    r = '0;
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (v[i]) r = MAX_IDX_W'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/sram_port_arbiter_rr.sv
// Round-robin arbiter: registered search pointer plus a masked/unmasked
// priority select. The masked half covers requesters at or above the
// pointer; if none of them request, the lowest unmasked requester wins.
module rr_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic               advance,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  logic [IDX_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] w_mask;
  logic [NUM_REQ-1:0] w_masked;
  logic [MAX_REQ-1:0] w_sel;

  // Priority select starting at the pointer; reset suppresses any grant.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_mask[i] = (i >= int'(r_ptr));
    end
    w_masked = req & w_mask;
    w_sel    = (|w_masked) ? MAX_REQ'(w_masked) : MAX_REQ'(req);
    gnt_vld  = (|req) && !rst;
    gnt_idx  = IDX_W'(lsb_index(w_sel));
    gnt      = '0;
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  // Pointer moves one past the winner on every grant, wrapping at NUM_REQ.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (advance) begin
      r_ptr <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares the read/write port of one 32x512 SRAM macro between NUM_REQ
// memory-stream masters. One access per cycle; every access (read or
// write) is answered on rvalid_o of its issuer one cycle later, with
// rdata_o passed straight through from the macro.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NUM_REQ-1:0]                     req_i,
  output logic [NUM_REQ-1:0]                     gnt_o,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     addr_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     wdata_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]   strb_i,
  input  logic [NUM_REQ-1:0]                     we_i,
  output logic [NUM_REQ-1:0]                     rvalid_o,
  output logic [DATA_WIDTH-1:0]                  rdata_o,
  output logic                                   sram_csb_o,
  output logic                                   sram_web_o,
  output logic [DATA_WIDTH/8-1:0]                sram_wmask_o,
  output logic [ADDR_WIDTH-3:0]                  sram_addr_o,
  output logic [DATA_WIDTH-1:0]                  sram_din_o,
  input  logic [DATA_WIDTH-1:0]                  sram_dout_i
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [IDX_W-1:0] w_idx;
  logic             w_gnt_vld;
  logic [IDX_W-1:0] r_rsp_idx;
  logic             r_rsp_vld;
  logic             w_unused_addr_lsbs;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .clk     (clk_i),
    .rst     (rst_i),
    .req     (req_i),
    .advance (w_gnt_vld),
    .gnt     (gnt_o),
    .gnt_idx (w_idx),
    .gnt_vld (w_gnt_vld)
  );

  // Byte-lane bits of the address never reach the word-addressed macro.
  always_comb begin
    w_unused_addr_lsbs = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_unused_addr_lsbs = w_unused_addr_lsbs ^ (^addr_i[i][1:0]);
    end
  end

  // Steer the winner onto the macro port; idle port is deselected and zeroed.
  always_comb begin
    sram_csb_o   = 1'b1;
    sram_web_o   = 1'b1;
    sram_wmask_o = '0;
    sram_addr_o  = '0;
    sram_din_o   = '0;
    if (w_gnt_vld) begin
      sram_csb_o   = 1'b0;
      sram_web_o   = !we_i[w_idx];
      sram_wmask_o = strb_i[w_idx];
      sram_addr_o  = addr_i[w_idx][ADDR_WIDTH-1:2];
      sram_din_o   = wdata_i[w_idx];
    end
  end

  // Remember who was granted so the response lands one cycle later;
  // reset drops any response still in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_vld <= 1'b0;
      r_rsp_idx <= '0;
    end else begin
      r_rsp_vld <= w_gnt_vld;
      r_rsp_idx <= w_idx;
    end
  end

  // Decode the registered response owner into the per-requester valid.
  always_comb begin
    rvalid_o = '0;
    if (r_rsp_vld) rvalid_o[r_rsp_idx] = 1'b1;
  end

  assign rdata_o = sram_dout_i;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter (NUM_REQ=2) with a behavioural
// model of the 32x512 macro: byte-masked writes, 1-cycle read latency.
module tb_sram_port_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       req;
  logic [1:0]       gnt;
  logic [1:0][10:0] addr;
  logic [1:0][31:0] wdata;
  logic [1:0][3:0]  strb;
  logic [1:0]       we;
  logic [1:0]       rvalid;
  logic [31:0]      rdata;
  logic             csb, web;
  logic [3:0]       wmask;
  logic [8:0]       saddr;
  logic [31:0]      din;
  logic [31:0]      dout;

  logic [31:0] mem [0:511];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.NUM_REQ(2), .ADDR_WIDTH(11), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr),
    .wdata_i(wdata), .strb_i(strb), .we_i(we), .rvalid_o(rvalid),
    .rdata_o(rdata), .sram_csb_o(csb), .sram_web_o(web),
    .sram_wmask_o(wmask), .sram_addr_o(saddr), .sram_din_o(din),
    .sram_dout_i(dout)
  );

  // Macro model
  always @(posedge clk) begin
    if (!csb) begin
      if (!web) begin
        for (int b = 0; b < 4; b++)
          if (wmask[b]) mem[saddr][b*8 +: 8] <= din[b*8 +: 8];
      end else begin
        dout <= mem[saddr];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic drive(input int r, input logic w, input logic [10:0] a,
                       input logic [31:0] d, input logic [3:0] s);
    we[r] = w; addr[r] = a; wdata[r] = d; strb[r] = s;
  endtask

  initial begin
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; strb = '0;
    nxt();
    // Reset dominates active requests
    req = 2'b11;
    #1;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_csb", 64'(csb), 64'h1);
    chk("rst_web", 64'(web), 64'h1);
    chk("rst_rvalid", 64'(rvalid), 64'h0);
    req = '0;
    nxt();
    rst = 1'b0;
    nxt();

    // Single requester: write then read 0x004
    req = 2'b01; drive(0, 1'b1, 11'h004, 32'hDEADBEEF, 4'hF);
    mid();
    chk("single_wr_gnt", 64'(gnt), 64'h1);
    chk("single_wr_csb", 64'(csb), 64'h0);
    chk("single_wr_web", 64'(web), 64'h0);
    chk("single_wr_addr", 64'(saddr), 64'h1);
    chk("single_wr_din", 64'(din), 64'hDEADBEEF);
    chk("single_wr_mask", 64'(wmask), 64'hF);
    nxt();
    drive(0, 1'b0, 11'h004, 32'h0, 4'h0);
    mid();
    chk("single_rd_gnt", 64'(gnt), 64'h1);
    chk("single_rd_web", 64'(web), 64'h1);
    chk("single_rd_addr", 64'(saddr), 64'h1);
    chk("single_wr_rvalid", 64'(rvalid), 64'h1);
    chk("single_wr_rdata_passthru", 64'(rdata), 64'(dout));
    nxt();
    req = '0;
    mid();
    chk("single_rd_rvalid", 64'(rvalid), 64'h1);
    chk("single_rd_rdata", 64'(rdata), 64'hDEADBEEF);
    chk("single_idle_gnt", 64'(gnt), 64'h0);
    chk("single_idle_csb", 64'(csb), 64'h1);
    chk("single_idle_addr", 64'(saddr), 64'h0);
    nxt();

    // Idle for 10 cycles: pointer stays one past requester 0
    for (int i = 0; i < 10; i++) begin
      mid();
      chk("idle_csb", 64'(csb), 64'h1);
      chk("idle_rvalid", 64'(rvalid), 64'h0);
      nxt();
    end
    chk("idle_ptr", 64'(dut.u_arb.r_ptr), 64'h1);

    // Byte mask by requester 1 at 0x010
    req = 2'b10; drive(1, 1'b1, 11'h010, 32'h11223344, 4'hF);
    mid();
    chk("mask_wr1_gnt", 64'(gnt), 64'h2);
    chk("mask_wr1_addr", 64'(saddr), 64'h4);
    nxt();
    drive(1, 1'b1, 11'h010, 32'hAABBCCDD, 4'h2);
    mid();
    chk("mask_wr2_mask", 64'(wmask), 64'h2);
    chk("mask_wr1_rvalid", 64'(rvalid), 64'h2);
    nxt();
    drive(1, 1'b0, 11'h010, 32'h0, 4'h0);
    mid();
    chk("mask_wr2_rvalid", 64'(rvalid), 64'h2);
    nxt();
    req = '0;
    mid();
    chk("mask_rd_rvalid", 64'(rvalid), 64'h2);
    chk("mask_rd_rdata", 64'(rdata), 64'h1122CC44);
    nxt();

    // Contention: both read for 6 cycles, grants alternate from requester 0
    req = 2'b11;
    drive(0, 1'b0, 11'h004, 32'h0, 4'h0);
    drive(1, 1'b0, 11'h010, 32'h0, 4'h0);
    for (int i = 0; i < 6; i++) begin
      mid();
      chk("fair_gnt", 64'(gnt), (i % 2 == 0) ? 64'h1 : 64'h2);
      if (i > 0) begin
        chk("fair_rvalid", 64'(rvalid), (i % 2 == 0) ? 64'h2 : 64'h1);
        chk("fair_rdata", 64'(rdata), (i % 2 == 0) ? 64'h1122CC44 : 64'hDEADBEEF);
      end
      nxt();
    end
    req = '0;
    mid();
    chk("fair_last_rvalid", 64'(rvalid), 64'h2);
    nxt();

    // Interleaved: requester 0 reads 0x004 while requester 1 writes 0x008
    req = 2'b11;
    drive(0, 1'b0, 11'h004, 32'h0, 4'h0);
    drive(1, 1'b1, 11'h008, 32'h00000055, 4'hF);
    mid();
    chk("il_rd_gnt", 64'(gnt), 64'h1);
    chk("il_rd_web", 64'(web), 64'h1);
    nxt();
    req = 2'b10;
    mid();
    chk("il_wr_gnt", 64'(gnt), 64'h2);
    chk("il_wr_addr", 64'(saddr), 64'h2);
    chk("il_wr_din", 64'(din), 64'h55);
    chk("il_rd_rvalid", 64'(rvalid), 64'h1);
    chk("il_rd_rdata", 64'(rdata), 64'hDEADBEEF);
    nxt();
    drive(1, 1'b0, 11'h008, 32'h0, 4'h0);
    mid();
    chk("il_wr_rvalid", 64'(rvalid), 64'h2);
    chk("il_wr_rdata_passthru", 64'(rdata), 64'(dout));
    nxt();
    req = '0;
    mid();
    chk("il_rb_rdata", 64'(rdata), 64'h55);
    nxt();

    // Zero-strobe write is granted and answered but leaves memory intact
    req = 2'b01; drive(0, 1'b1, 11'h004, 32'h0, 4'h0);
    mid();
    chk("zs_gnt", 64'(gnt), 64'h1);
    chk("zs_web", 64'(web), 64'h0);
    chk("zs_mask", 64'(wmask), 64'h0);
    nxt();
    drive(0, 1'b0, 11'h004, 32'h0, 4'h0);
    mid();
    chk("zs_rvalid", 64'(rvalid), 64'h1);
    nxt();
    req = '0;
    mid();
    chk("zs_rdata", 64'(rdata), 64'hDEADBEEF);
    nxt();

    // Reset mid-operation: pending read response is dropped
    req = 2'b01;
    mid();
    chk("rm_gnt", 64'(gnt), 64'h1);
    nxt();
    chk("rm_rvalid_before", 64'(rvalid), 64'h1);
    req = 2'b11;
    rst = 1'b1;
    #1;
    chk("rm_rvalid_async", 64'(rvalid), 64'h0);
    chk("rm_csb_async", 64'(csb), 64'h1);
    chk("rm_gnt_async", 64'(gnt), 64'h0);
    nxt();
    mid();
    chk("rm_held_rvalid", 64'(rvalid), 64'h0);
    rst = 1'b0;
    #1;
    chk("rm_first_gnt", 64'(gnt), 64'h1);
    nxt();
    mid();
    chk("rm_second_gnt", 64'(gnt), 64'h2);
    chk("rm_second_rvalid", 64'(rvalid), 64'h1);
    nxt();
    req = '0;
    nxt();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Round-robin arbiter sharing the read/write port of one `sky130_sram_2kbyte_1rw1r_32x512_8` macro between `NUM_REQ` memory-stream masters, such as the outputs of several `axi_to_mem_intf` bridges. It issues at most one SRAM access per cycle and returns every response one cycle later to the requester that issued it. It replaces the always-grant glue between a single bridge and the macro when a RAM is shared.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 2..8.
- `ADDR_WIDTH`, 11: byte address width. SRAM word address is `[ADDR_WIDTH-1:2]`.
- `DATA_WIDTH`, 32: data width. Strobe width is `DATA_WIDTH/8`.

Ports:
- `clk_i`  in  1  clock; all state on the rising edge.
- `rst_i`  in  1  asynchronous reset, active-high.
- `req_i`  in  NUM_REQ  per-requester request valid.
- `gnt_o`  out  NUM_REQ  per-requester grant; at most one bit set.
- `addr_i`  in  NUM_REQ x ADDR_WIDTH  byte addresses.
- `wdata_i`  in  NUM_REQ x DATA_WIDTH  write data.
- `strb_i`  in  NUM_REQ x DATA_WIDTH/8  byte enables.
- `we_i`  in  NUM_REQ  write enable.
- `rvalid_o`  out  NUM_REQ  response valid, one per granted request (reads and writes).
- `rdata_o`  out  DATA_WIDTH  read data, shared by all requesters; qualified by `rvalid_o`.
- `sram_csb_o`  out  1  macro chip select, active-low.
- `sram_web_o`  out  1  macro write enable, active-low.
- `sram_wmask_o`  out  DATA_WIDTH/8  macro byte mask.
- `sram_addr_o`  out  ADDR_WIDTH-2  macro word address.
- `sram_din_o`  out  DATA_WIDTH  macro write data.
- `sram_dout_i`  in  DATA_WIDTH  macro read data, valid one cycle after the access.

## Operation
- **Arbitration.** Combinational round-robin over `req_i`. The search starts at `rr_ptr`, a registered index of width clog2(NUM_REQ). The winner `w` gets `gnt_o[w]=1`.
- **Pointer update.** On any grant, `rr_ptr <= w+1`, wrapping from NUM_REQ-1 to 0. With no request, `rr_ptr` holds.
- **SRAM drive.** While a grant is active: `sram_csb_o=0`, `sram_web_o=!we_i[w]`, and the address, mask and write data come from requester `w`. With no grant: `sram_csb_o=1`, `sram_web_o=1`, and the remaining SRAM outputs are 0.
- **Response tracking.** Registered `rsp_vld`/`rsp_idx` capture the grant. The cycle after a grant, `rvalid_o[rsp_idx]=1` and `rdata_o=sram_dout_i`.
- **Write responses.** A write also produces `rvalid_o`, as `axi_to_mem_intf` requires. `rdata_o` is don't-care for writes, but the bench checks that it equals `sram_dout_i`.
- **Zero-strobe writes.** A write with `strb_i=0` is still granted and still answered. Hiding such writes is the bridge's job.
- **Flow control.** No backpressure on responses. Requesters must accept `rvalid_o` unconditionally. The bridge with `BUF_DEPTH>=1` satisfies this.
- **Reset.** `rst_i` asserted forces the following, even while `req_i` is active:
  - `gnt_o=0`
  - `sram_csb_o=1`, `sram_web_o=1`
  - `rvalid_o=0`
  - `rr_ptr=0`, `rsp_vld=0`
  
  A response pending when reset asserts is dropped.

## Timing
- Grant is combinational from `req_i` in the same cycle, with 0 cycles of added request latency.
- Response latency is exactly 1 cycle after the grant. `rvalid_o` is registered; `rdata_o` is a combinational pass-through of the macro output.
- Throughput is 1 access per cycle aggregate. A requester holding `req_i` alone is granted every cycle, back-to-back.
- Under full contention from all NUM_REQ requesters, each one is granted exactly once every NUM_REQ cycles.
- Grant and response in the same cycle is the normal pipelined case: cycle N's `rvalid_o` and cycle N's `gnt_o` may target different requesters.
- Reset release: the first grant is possible in the first clock edge window after `rst_i` deasserts, and the search starts at requester 0.

## Structure
- Do not put macro geometry in a package; derive it from the parameters.
- Use one sub-module, `rr_arbiter`, holding the pointer register and the masked/unmasked priority select. It takes `req` and `advance` and returns a one-hot grant plus the grant index.
- The top level holds the response register, the mux to the SRAM, and the `rvalid_o` decode.

## Test plan
- **Single requester.** NUM_REQ=2. Requester 0 writes 0xDEADBEEF to byte address 0x004 with strb=0xF, then reads 0x004.
  - Expect `gnt_o=01` both cycles, with `sram_addr_o=1` on both accesses.
  - Expect `rvalid_o[0]` one cycle after each access.
  - Expect read data 0xDEADBEEF.
- **Contention fairness.** Both requesters hold `req_i` for 6 cycles.
  - Expect `gnt_o` to alternate 01,10,01,10,01,10.
  - Expect `rvalid_o` to follow one cycle later with the same pattern.
- **Byte mask.** Write 0x11223344 to address 0x010, then write 0xAABBCCDD with strb=0x2, then read.
  - Expect read data 0x1122CC44.
- **Interleaved read/write.** Requester 0 reads 0x004 while requester 1 writes 0x55 to 0x008 in the same cycle.
  - Expect read data 0xDEADBEEF routed only to `rvalid_o[0]`.
  - Expect the write response only on `rvalid_o[1]`, one cycle after its own grant.
- **Reset mid-operation.** Assert `rst_i` in the cycle after a read grant.
  - Expect `rvalid_o=0` and `sram_csb_o=1` immediately, asynchronously.
  - After release with both requesters requesting, expect the first grant to go to requester 0.
- **Idle.** With `req_i=0` for 10 cycles, expect `sram_csb_o=1`, `rvalid_o=0`, and `rr_ptr` unchanged.
